data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port DATA_MEM between two requesters: the core sequencer (port "core")
//  and the host/debug loader (port "host").
//  Arbitrates with registered grants, supports locked multi-access sequences (e.g. MEM_TO_MEM
//  read-then-write), bounds lock length and returns read data with a 1-cycle valid strobe.
//  Sits between the FETCH/DECODE/EXEC/WRITE_BACK controller and DATA_MEM_inst.
// PARAMETERS
//  DATA_SIZE  8  data width, bits
//  ADDR_SIZE  4  data memory address width, bits
//  MAX_LOCK   4  max consecutive accepted accesses per grant while the other port waits; >=1
// PORTS
//  clk          input   1          clock, all logic on posedge
//  rst          input   1          synchronous, active-high reset
//  core_req     input   1          core requests an access this cycle
//  core_lock    input   1          core keeps the grant after the current access
//  core_we      input   1          1 = write, 0 = read
//  core_addr    input   ADDR_SIZE  access address
//  core_wdata   input   DATA_SIZE  write data
//  core_gnt     output  1          core owns the memory (registered)
//  core_rvalid  output  1          core_rdata valid (registered)
//  core_rdata   output  DATA_SIZE  read data
//  host_*       same set as core_*, for the host port
//  mem_we       output  1          to DATA_MEM W
//  mem_addr     output  ADDR_SIZE  to DATA_MEM ADDR
//  mem_wdata    output  DATA_SIZE  to DATA_MEM DATA_WR
//  mem_rdata    input   DATA_SIZE  from DATA_MEM DATA_RD; valid 1 cycle after a read address
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; gnt, rvalid, mem_we=0; rdata=0; lock_cnt=0;
//    last_winner=HOST, so core wins the first tie.
//  - FSM IDLE / OWN_CORE / OWN_HOST; gnt = (state==OWN_x), driven from the state register.
//  - IDLE: no req -> IDLE.
//    One req -> OWN_that.
//    Both req -> OWN_ port that is not last_winner (round robin).
//    req at cycle N -> gnt at N+1.
//  - Access accepted at a cycle when x_gnt & x_req.
//    mem_we/addr/wdata are combinational from the owner that cycle.
//    Otherwise mem_we=0, mem_addr=0, mem_wdata=0.
//  - Read accepted at N -> x_rvalid=1 and x_rdata=mem_rdata at N+1.
//    rvalid is routed to the issuer even if the grant moved. rdata holds its value between strobes.
//  - lock_cnt counts accepted accesses in the current grant; it clears on every grant change.
//  - Leaving OWN_x (evaluated at the posedge after the cycle):
//    * release = (accepted & ~x_lock) | ~x_req | (accepted & lock_cnt+1==MAX_LOCK & other_req).
//    * If release and other_req -> OWN_other directly (no idle cycle).
//    * If release and no other_req -> IDLE.
//    * last_winner=x on release.
//  - No release -> stay OWN_x; back-to-back accesses run one per cycle.
//  - MAX_LOCK applies only when the other port requests. An uncontended lock is unbounded.
//  - A requester must hold addr/we/wdata stable while req=1 and gnt=0.
//    A write is performed once per accepted cycle.
//  - Reset mid-operation: grant dropped next cycle. A pending rvalid is discarded (rvalid=0).
// CONFIGURATION
//  - ARB_HOST_PRIO_EN defined:
//    * Fixed priority. Host wins every tie in IDLE.
//    * When host_req is set during OWN_CORE, core is released after its next accepted access,
//      regardless of core_lock or lock_cnt.
//    * Core is never forced off a grant while host is idle.
//  - ARB_HOST_PRIO_EN undefined: round-robin plus MAX_LOCK fairness, as above.
// TESTING
//  1. Core-only read: core_req=1, we=0, addr=3, mem[3]=0x5A.
//     -> gnt at N+1, accepted N+1, core_rvalid=1 and rdata=0x5A at N+2, then IDLE.
//  2. Tie after reset: both req in the same cycle.
//     -> core_gnt first. Next tie -> host_gnt. Grants never overlap.
//  3. Locked MEM_TO_MEM: core reads 2 with lock=1, then writes 9 with lock=0, host waiting.
//     -> host_gnt only after the write. mem[9] = the old mem[2].
//  4. Lock bound with MAX_LOCK=4: core lock=1 continuously, host_req=1.
//     -> exactly 4 core accesses, then host_gnt the next cycle.
//  5. Reset mid-read: rst=1 in the cycle after a host read is accepted.
//     -> host_rvalid=0, both gnt=0, mem_we=0.
//  6. With ARB_HOST_PRIO_EN: core locked, host_req rises.
//     -> core released after one more access. Ties resolve to host 3 times in a row.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port (core/host) arbiter in front of the single-port DATA_MEM: registered grants,
// locked sequences with MAX_LOCK fairness. Define ARB_HOST_PRIO_EN for fixed host priority.
module data_mem_arbiter #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4,
   parameter int MAX_LOCK  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 core_req,
   input  logic                 core_lock,
   input  logic                 core_we,
   input  logic [ADDR_SIZE-1:0] core_addr,
   input  logic [DATA_SIZE-1:0] core_wdata,
   output logic                 core_gnt,
   output logic                 core_rvalid,
   output logic [DATA_SIZE-1:0] core_rdata,
   input  logic                 host_req,
   input  logic                 host_lock,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [DATA_SIZE-1:0] host_wdata,
   output logic                 host_gnt,
   output logic                 host_rvalid,
   output logic [DATA_SIZE-1:0] host_rdata,
   output logic                 mem_we,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [DATA_SIZE-1:0] mem_wdata,
   input  logic [DATA_SIZE-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, OWN_CORE, OWN_HOST} state_t;
   localparam int LCW = $clog2(MAX_LOCK + 1);

   state_t               state_q, state_d;
   logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
   logic                 core_rvalid_q, core_rvalid_d;
   logic                 host_rvalid_q, host_rvalid_d;
   logic [DATA_SIZE-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_SIZE-1:0] host_rdata_q, host_rdata_d;

   logic core_acc, host_acc, core_rel, host_rel, lock_last;

   assign core_acc  = (state_q == OWN_CORE) & core_req;
   assign host_acc  = (state_q == OWN_HOST) & host_req;
   // Counter saturates, so an uncontended lock that outlived MAX_LOCK yields after its next access.
   assign lock_last = (lock_cnt_q == LCW'(MAX_LOCK - 1));

`ifdef ARB_HOST_PRIO_EN
   assign core_rel = (core_acc & ~core_lock) | ~core_req | (core_acc & host_req);
`else
   assign core_rel = (core_acc & ~core_lock) | ~core_req | (core_acc & lock_last & host_req);

   logic last_host_q, last_host_d;

   always_comb begin
      last_host_d = last_host_q;
      if ((state_q == OWN_CORE) && core_rel) last_host_d = 1'b0;
      if ((state_q == OWN_HOST) && host_rel) last_host_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) last_host_q <= 1'b1;
      else     last_host_q <= last_host_d;
   end
`endif
   // The host keeps MAX_LOCK fairness in both builds so a locked host cannot starve the core.
   assign host_rel = (host_acc & ~host_lock) | ~host_req | (host_acc & lock_last & core_req);

   // State register plus datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         lock_cnt_q    <= '0;
         core_rvalid_q <= 1'b0;
         host_rvalid_q <= 1'b0;
         core_rdata_q  <= '0;
         host_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         lock_cnt_q    <= lock_cnt_d;
         core_rvalid_q <= core_rvalid_d;
         host_rvalid_q <= host_rvalid_d;
         core_rdata_q  <= core_rdata_d;
         host_rdata_q  <= host_rdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
`ifdef ARB_HOST_PRIO_EN
            if (host_req)      state_d = OWN_HOST;
            else if (core_req) state_d = OWN_CORE;
`else
            if (core_req && host_req) state_d = last_host_q ? OWN_CORE : OWN_HOST;
            else if (core_req)        state_d = OWN_CORE;
            else if (host_req)        state_d = OWN_HOST;
`endif
         end
         OWN_CORE: if (core_rel) state_d = host_req ? OWN_HOST : IDLE;
         OWN_HOST: if (host_rel) state_d = core_req ? OWN_CORE : IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (state_d != state_q)                 lock_cnt_d = '0;
      else if ((core_acc | host_acc) && !lock_last) lock_cnt_d = lock_cnt_q + 1'b1;

      core_rvalid_d = core_acc & ~core_we;
      host_rvalid_d = host_acc & ~host_we;
      core_rdata_d  = core_rvalid_q ? mem_rdata : core_rdata_q;
      host_rdata_d  = host_rvalid_q ? mem_rdata : host_rdata_q;
   end

   // Outputs
   always_comb begin
      core_gnt    = (state_q == OWN_CORE);
      host_gnt    = (state_q == OWN_HOST);
      core_rvalid = core_rvalid_q;
      host_rvalid = host_rvalid_q;
      core_rdata  = core_rvalid_q ? mem_rdata : core_rdata_q;
      host_rdata  = host_rvalid_q ? mem_rdata : host_rdata_q;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (core_acc) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else if (host_acc) begin
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a registered-read memory model.
// Round-robin scenarios run in the default build, host-priority scenarios with ARB_HOST_PRIO_EN.
module tb_data_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_init = 1'b1;
   logic       core_req = 0, core_lock = 0, core_we = 0;
   logic [3:0] core_addr = 0;
   logic [7:0] core_wdata = 0;
   logic       host_req = 0, host_lock = 0, host_we = 0;
   logic [3:0] host_addr = 0;
   logic [7:0] host_wdata = 0;
   logic       core_gnt, core_rvalid, host_gnt, host_rvalid, mem_we;
   logic [7:0] core_rdata, host_rdata, mem_wdata;
   logic [7:0] mem_rdata;
   logic [3:0] mem_addr;
   logic [7:0] mem [16];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(4), .MAX_LOCK(4)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_lock(core_lock), .core_we(core_we),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .host_req(host_req), .host_lock(host_lock), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // mem[3]=0x5A, otherwise mem[i] = {i, ~i}
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 8'h5A : {4'(i), ~4'(i)};
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      core_req = 0; core_lock = 0; core_we = 0; core_addr = 0; core_wdata = 0;
      host_req = 0; host_lock = 0; host_we = 0; host_addr = 0; host_wdata = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({core_gnt, host_gnt, core_rvalid, host_rvalid, mem_we} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 00000", {core_gnt, host_gnt, core_rvalid, host_rvalid, mem_we});
      end
      checks++;
      if ({core_rdata, host_rdata, mem_addr} !== 20'h0) begin
         errors++;
         $display("FAIL reset_data: got %h want 00000", {core_rdata, host_rdata, mem_addr});
      end
   endtask

   task automatic test_core_read();
      do_reset();
      core_req = 1; core_addr = 4'd3;
      #1;
      checks++;
      if ({core_gnt, mem_we, mem_addr} !== 6'b0) begin
         errors++;
         $display("FAIL core_read_idle_mux: got %b want 000000", {core_gnt, mem_we, mem_addr});
      end
      step();
      checks++;
      if ({core_gnt, host_gnt, mem_we, mem_addr} !== {3'b100, 4'd3}) begin
         errors++;
         $display("FAIL core_read_grant: got %b want 1000011", {core_gnt, host_gnt, mem_we, mem_addr});
      end
      step();
      core_req = 0;
      checks++;
      if ({core_gnt, core_rvalid, host_rvalid, core_rdata} !== {3'b010, 8'h5A}) begin
         errors++;
         $display("FAIL core_read_data: got %b_%h want 010_5a", {core_gnt, core_rvalid, host_rvalid}, core_rdata);
      end
      step();
      checks++;
      if ({core_rvalid, core_rdata} !== {1'b0, 8'h5A}) begin
         errors++;
         $display("FAIL core_read_hold: got %b_%h want 0_5a", core_rvalid, core_rdata);
      end
   endtask

   task automatic test_tie_round_robin();
      do_reset();
      core_req = 1; host_req = 1; core_addr = 4'd1; host_addr = 4'd2;
      step();
      checks++;
      if ({core_gnt, host_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL tie_first: got %b want 10", {core_gnt, host_gnt});
      end
      host_req = 0;
      step();
      checks++;
      if ({core_gnt, host_gnt} !== 2'b00) begin
         errors++;
         $display("FAIL tie_idle_gap: got %b want 00", {core_gnt, host_gnt});
      end
      host_req = 1;
      step();
      checks++;
      if ({core_gnt, host_gnt} !== 2'b01) begin
         errors++;
         $display("FAIL tie_second: got %b want 01", {core_gnt, host_gnt});
      end
      step();
      checks++;
      if ({core_gnt, host_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL tie_handover: got %b want 10", {core_gnt, host_gnt});
      end
      idle_inputs();
      step();
   endtask

   task automatic test_locked_mem_to_mem();
      do_reset();
      core_req = 1; core_lock = 1; core_addr = 4'd2;
      host_req = 1; host_we = 1; host_addr = 4'd5; host_wdata = 8'h77;
      step();
      checks++;
      if ({core_gnt, host_gnt, mem_we, mem_addr} !== {3'b100, 4'd2}) begin
         errors++;
         $display("FAIL m2m_read: got %b want 1000010", {core_gnt, host_gnt, mem_we, mem_addr});
      end
      step();
      checks++;
      if ({core_gnt, host_gnt, core_rvalid, core_rdata} !== {3'b101, 8'h2D}) begin
         errors++;
         $display("FAIL m2m_locked: got %b_%h want 101_2d", {core_gnt, host_gnt, core_rvalid}, core_rdata);
      end
      core_we = 1; core_addr = 4'd9; core_lock = 0; core_wdata = core_rdata;
      #1;
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd9, 8'h2D}) begin
         errors++;
         $display("FAIL m2m_write_mux: got %b_%h_%h want 1_9_2d", mem_we, mem_addr, mem_wdata);
      end
      step();
      core_req = 0;
      checks++;
      if ({core_gnt, host_gnt, mem[9]} !== {2'b01, 8'h2D}) begin
         errors++;
         $display("FAIL m2m_host_after: got %b_%h want 01_2d", {core_gnt, host_gnt}, mem[9]);
      end
      step();
      host_req = 0;
      checks++;
      if ({host_gnt, mem[5]} !== {1'b0, 8'h77}) begin
         errors++;
         $display("FAIL m2m_host_write: got %b_%h want 0_77", host_gnt, mem[5]);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_lock_bound();
      int core_n = 0;
      int first_host = -1;
      bit overlap = 0;
      do_reset();
      core_req = 1; core_lock = 1; core_addr = 4'd0;
      host_req = 1; host_addr = 4'd1;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (core_gnt && host_gnt) overlap = 1;
         if (first_host < 0 && core_gnt && core_req) core_n++;
         if (first_host < 0 && host_gnt) first_host = c;
      end
      checks++;
      if (core_n !== 4 || first_host !== 5) begin
         errors++;
         $display("FAIL lock_bound: core accesses %0d host grant cycle %0d, want 4 and 5", core_n, first_host);
      end
      checks++;
      if (overlap !== 1'b0) begin
         errors++;
         $display("FAIL lock_bound_overlap: got %b want 0", overlap);
      end
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_uncontended_lock();
      int gnt_n = 0;
      do_reset();
      core_req = 1; core_lock = 1; core_addr = 4'd4;
      step();
      for (int c = 0; c < 7; c++) begin
         if (core_gnt) gnt_n++;
         step();
      end
      checks++;
      if (gnt_n !== 7) begin
         errors++;
         $display("FAIL uncontended_lock: grant cycles %0d want 7", gnt_n);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      host_req = 1; host_lock = 1; host_addr = 4'd7;
      step();
      checks++;
      if ({host_gnt, core_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL midrst_grant: got %b want 10", {host_gnt, core_gnt});
      end
      step();
      rst = 1;
      checks++;
      if ({host_rvalid, host_rdata} !== {1'b1, 8'h78}) begin
         errors++;
         $display("FAIL midrst_pre: got %b_%h want 1_78", host_rvalid, host_rdata);
      end
      step();
      rst = 0; host_req = 0; host_lock = 0;
      #1;
      checks++;
      if ({host_rvalid, host_gnt, core_gnt, mem_we, host_rdata} !== {4'b0000, 8'h00}) begin
         errors++;
         $display("FAIL midrst_after: got %b_%h want 0000_00", {host_rvalid, host_gnt, core_gnt, mem_we}, host_rdata);
      end
      step();
   endtask

   task automatic test_host_prio();
      do_reset();
      core_req = 1; core_lock = 1; core_addr = 4'd1;
      step();
      step();
      checks++;
      if ({core_gnt, host_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL prio_core_locked: got %b want 10", {core_gnt, host_gnt});
      end
      host_req = 1; host_addr = 4'd2;
      step();
      checks++;
      if ({core_gnt, host_gnt} !== 2'b01) begin
         errors++;
         $display("FAIL prio_preempt: got %b want 01", {core_gnt, host_gnt});
      end
      idle_inputs();
      step();
      step();
      for (int k = 0; k < 3; k++) begin
         core_req = 1; host_req = 1;
         step();
         checks++;
         if ({core_gnt, host_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL prio_tie_%0d: got %b want 01", k, {core_gnt, host_gnt});
         end
         idle_inputs();
         step();
         step();
      end
   endtask

   initial begin
      step();
      step();
      mem_init = 0;
      test_reset();
      test_core_read();
      test_uncontended_lock();
      test_reset_mid_read();
`ifdef ARB_HOST_PRIO_EN
      test_host_prio();
`else
      test_tie_round_robin();
      test_locked_mem_to_mem();
      test_lock_bound();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
